// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the signals between the memory arbiter, its two
// CPU-side requesters (instruction fetch and data load/store) and the shared
// synchronous SRAM port.
//
//   slave  modport : the arbiter. It takes the requests and sram_rdata, and
//                    drives the completions, the stall request and the SRAM
//                    control outputs.
//   master modport : the surroundings, i.e. the CPU ports and the SRAM.
//
// Handshake: a requester raises *_req with stable address and data and holds it
// until the matching one-cycle *_ack. Read data is valid in the ack cycle.
// The arbiter samples requests only when it makes a grant decision.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stallreq;
  logic        sram_ce;
  logic        sram_we;
  logic [3:0]  sram_sel;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, sram_rdata,
    output if_data, if_ack, d_rdata, d_ack, stallreq,
           sram_ce, sram_we, sram_sel, sram_addr, sram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_sel, d_addr, d_wdata, sram_rdata,
    input  if_data, if_ack, d_rdata, d_ack, stallreq,
           sram_ce, sram_we, sram_sel, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data accesses onto one SRAM
// port. Each access holds the SRAM outputs for WAIT_CYCLES+1 cycles and then
// returns a one-cycle ack, with read data registered alongside it.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : mem_arbiter_if.slave (requesters, stall request, SRAM port)
//   state_o : current FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D)
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic [1:0]     state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        last_q;   // 1 = data port granted last, 0 = fetch port
  logic        sram_ce_q;
  logic        sram_we_q;
  logic [3:0]  sram_sel_q;
  logic [31:0] sram_addr_q;
  logic [31:0] sram_wdata_q;
  logic [31:0] if_data_q;
  logic [31:0] d_rdata_q;
  logic        if_ack_q;
  logic        d_ack_q;

  logic        decide_d;
  logic        grant_dat_d;
  logic        grant_ins_d;

  // A grant is made from IDLE and again in the completion cycle of an access,
  // so back-to-back accesses leave no idle gap. Under contention the data port
  // wins unless it won the previous grant.
  always_comb begin
    decide_d    = (state_q == IDLE) || (cnt_q == 3'd0);
    grant_dat_d = bus.d_req && (!bus.if_req || !last_q);
    grant_ins_d = bus.if_req && !grant_dat_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      last_q       <= 1'b1;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_sel_q   <= 4'd0;
      sram_addr_q  <= 32'd0;
      sram_wdata_q <= 32'd0;
      if_data_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;

      if (state_q != IDLE && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end

      // Completion: sram_rdata is valid in this cycle.
      if (state_q == BUSY_I && cnt_q == 3'd0) begin
        if_data_q <= bus.sram_rdata;
        if_ack_q  <= 1'b1;
      end
      if (state_q == BUSY_D && cnt_q == 3'd0) begin
        if (!sram_we_q) begin
          d_rdata_q <= bus.sram_rdata;   // stores leave d_rdata untouched
        end
        d_ack_q <= 1'b1;
      end

      if (decide_d) begin
        if (grant_dat_d) begin
          state_q      <= BUSY_D;
          cnt_q        <= WAIT_INIT;
          last_q       <= 1'b1;
          sram_ce_q    <= 1'b1;
          sram_we_q    <= bus.d_we;
          sram_sel_q   <= bus.d_sel;
          sram_addr_q  <= bus.d_addr;
          sram_wdata_q <= bus.d_wdata;
        end else if (grant_ins_d) begin
          state_q      <= BUSY_I;
          cnt_q        <= WAIT_INIT;
          last_q       <= 1'b0;
          sram_ce_q    <= 1'b1;
          sram_we_q    <= 1'b0;
          sram_sel_q   <= 4'b1111;
          sram_addr_q  <= bus.if_addr;
          sram_wdata_q <= 32'd0;
        end else begin
          state_q   <= IDLE;
          sram_ce_q <= 1'b0;
          sram_we_q <= 1'b0;   // never leave a write strobe without chip enable
        end
      end
    end
  end

  // Stall stays up until the requester sees its ack.
  assign bus.stallreq   = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
  assign bus.if_data    = if_data_q;
  assign bus.if_ack     = if_ack_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.sram_ce    = sram_ce_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_sel   = sram_sel_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share clock and reset:
// u_dut1 runs with WAIT_CYCLES=1 and u_dut0 with WAIT_CYCLES=0. A small
// word-addressed SRAM model (16 words, indexed by addr[5:2]) answers both
// instances. Only u_dut0 issues stores, so only its port writes the model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if b1 ();
  mem_arbiter_if b0 ();
  logic [1:0] st1;
  logic [1:0] st0;

  mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1), .state_o(st1));
  mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0), .state_o(st0));

  logic [31:0] mem [16] = '{
    32'h0000_0000, 32'h2401_0005, 32'hCAFE_0002, 32'h3333_3333,
    32'h1122_3344, 32'h55AA_55AA, 32'h0000_0006, 32'h0000_0007,
    32'h0000_0008, 32'h0000_0009, 32'h0000_000A, 32'h0000_000B,
    32'h0000_000C, 32'h0000_000D, 32'h0000_000E, 32'h0000_000F
  };

  assign b1.sram_rdata = mem[b1.sram_addr[5:2]];
  assign b0.sram_rdata = mem[b0.sram_addr[5:2]];

  always @(posedge clk) begin
    if (b0.sram_ce && b0.sram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (b0.sram_sel[i]) mem[b0.sram_addr[5:2]][8*i +: 8] <= b0.sram_wdata[8*i +: 8];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b1.if_req = 1'b0; b1.if_addr = 32'd0; b1.d_req = 1'b0; b1.d_we = 1'b0;
    b1.d_sel = 4'd0;  b1.d_addr = 32'd0;  b1.d_wdata = 32'd0;
    b0.if_req = 1'b0; b0.if_addr = 32'd0; b0.d_req = 1'b0; b0.d_we = 1'b0;
    b0.d_sel = 4'd0;  b0.d_addr = 32'd0;  b0.d_wdata = 32'd0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset values ----------------
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("rst_sram_ce",    b1.sram_ce,    0);
    chk("rst_sram_addr",  b1.sram_addr,  0);
    chk("rst_sram_sel",   b1.sram_sel,   0);
    chk("rst_if_data",    b1.if_data,    0);
    chk("rst_d_rdata",    b1.d_rdata,    0);
    chk("rst_acks",       {b1.if_ack, b1.d_ack, b0.if_ack, b0.d_ack}, 0);
    chk("rst_stallreq",   b1.stallreq,   0);
    chk("rst_state",      st1,           0);
    tick(); tick();
    rst = 1'b1;

    // ---------------- reset mid-access (W=1) ----------------
    b1.if_req = 1'b1; b1.if_addr = 32'h40;
    tick();                                   // grant edge
    chk("mid_grant_ce",    b1.sram_ce, 1);
    chk("mid_grant_state", st1,        1);
    chk("mid_grant_addr",  b1.sram_addr, 32'h40);
    tick();                                   // completion cycle, one after grant
    rst = 1'b0;
    #1;
    chk("mid_rst_ce",       b1.sram_ce,   0);
    chk("mid_rst_addr",     b1.sram_addr, 0);
    chk("mid_rst_state",    st1,          0);
    chk("mid_rst_stallreq", b1.stallreq,  1);
    b1.if_req = 1'b0;
    tick();
    chk("mid_rst_no_ack1", b1.if_ack, 0);
    tick();
    chk("mid_rst_no_ack2", b1.if_ack,  0);
    chk("mid_rst_if_data", b1.if_data, 0);
    rst = 1'b1;

    // ---------------- single fetch (W=1) ----------------
    b1.if_req = 1'b1; b1.if_addr = 32'h4;
    #1;
    chk("fetch_c0_stall", b1.stallreq, 1);
    tick();
    chk("fetch_c1_ce",    b1.sram_ce,   1);
    chk("fetch_c1_addr",  b1.sram_addr, 32'h4);
    chk("fetch_c1_sel",   b1.sram_sel,  4'hF);
    chk("fetch_c1_we",    b1.sram_we,   0);
    chk("fetch_c1_ack",   b1.if_ack,    0);
    chk("fetch_c1_stall", b1.stallreq,  1);
    tick();
    chk("fetch_c2_ce",    b1.sram_ce,   1);
    chk("fetch_c2_stall", b1.stallreq,  1);
    b1.if_req = 1'b0;
    tick();
    chk("fetch_c3_ack",   b1.if_ack,    1);
    chk("fetch_c3_data",  b1.if_data,   32'h2401_0005);
    chk("fetch_c3_ce",    b1.sram_ce,   0);
    chk("fetch_c3_state", st1,          0);
    chk("fetch_c3_stall", b1.stallreq,  0);
    tick();
    chk("fetch_c4_ack",   b1.if_ack,    0);
    chk("fetch_c4_data",  b1.if_data,   32'h2401_0005);

    // ---------------- store then load, same address (W=0) ----------------
    b0.d_req = 1'b1; b0.d_we = 1'b1; b0.d_sel = 4'b0011;
    b0.d_addr = 32'h10; b0.d_wdata = 32'hAABB_CCDD;
    tick();
    chk("st_c1_ce",    b0.sram_ce,    1);
    chk("st_c1_we",    b0.sram_we,    1);
    chk("st_c1_sel",   b0.sram_sel,   4'b0011);
    chk("st_c1_addr",  b0.sram_addr,  32'h10);
    chk("st_c1_wdata", b0.sram_wdata, 32'hAABB_CCDD);
    chk("st_c1_state", st0,           2);
    b0.d_we = 1'b0; b0.d_sel = 4'hF;
    tick();
    chk("st_c2_ack",   b0.d_ack,   1);
    chk("st_c2_rdata", b0.d_rdata, 0);
    chk("ld_c2_we",    b0.sram_we, 0);
    chk("ld_c2_ce",    b0.sram_ce, 1);
    b0.d_req = 1'b0;
    tick();
    chk("ld_c3_ack",   b0.d_ack,   1);
    chk("ld_c3_rdata", b0.d_rdata, 32'h1122_CCDD);
    chk("ld_c3_ce",    b0.sram_ce, 0);
    tick();
    chk("ld_c4_ack",   b0.d_ack,   0);

    // ---------------- contention (W=0) ----------------
    // A lone fetch first makes fetch the last grant, so contention opens with data.
    b0.if_req = 1'b1; b0.if_addr = 32'h8;
    tick();
    chk("cont_pre_state", st0, 1);
    b0.d_req = 1'b1; b0.d_we = 1'b0; b0.d_sel = 4'hF; b0.d_addr = 32'h14;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("cont_state_%0d", k),  st0,        (k % 2 == 0) ? 2 : 1);
      chk($sformatf("cont_ce_%0d", k),     b0.sram_ce, 1);
      chk($sformatf("cont_if_ack_%0d", k), b0.if_ack,  (k % 2 == 0) ? 1 : 0);
      chk($sformatf("cont_d_ack_%0d", k),  b0.d_ack,   (k % 2 == 0) ? 0 : 1);
      if (k % 2 == 0) chk($sformatf("cont_if_data_%0d", k), b0.if_data, 32'hCAFE_0002);
      else            chk($sformatf("cont_d_rdata_%0d", k), b0.d_rdata, 32'h55AA_55AA);
    end
    b0.if_req = 1'b0; b0.d_req = 1'b0;
    tick();
    chk("cont_end_if_ack", b0.if_ack, 1);
    chk("cont_end_state",  st0,       0);
    chk("cont_end_ce",     b0.sram_ce, 0);
    tick();
    chk("cont_quiet_ack", {b0.if_ack, b0.d_ack}, 0);

    // ---------------- requester drop (W=1) ----------------
    b1.if_req = 1'b1; b1.if_addr = 32'h4;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_sel = 4'hF; b1.d_addr = 32'h14;
    tick();
    chk("drop_c1_state", st1, 2);
    b1.d_req = 1'b0;
    #1;
    chk("drop_c1_stall", b1.stallreq, 1);
    tick();
    chk("drop_c2_state", st1,      2);
    chk("drop_c2_ack",   b1.d_ack, 0);
    tick();
    chk("drop_c3_ack",   b1.d_ack,     1);
    chk("drop_c3_rdata", b1.d_rdata,   32'h55AA_55AA);
    chk("drop_c3_state", st1,          1);
    chk("drop_c3_addr",  b1.sram_addr, 32'h4);
    tick();
    chk("drop_c4_ack",   b1.d_ack, 0);
    chk("drop_c4_state", st1,      1);
    b1.if_req = 1'b0;
    tick();
    chk("drop_c5_if_ack",  b1.if_ack,  1);
    chk("drop_c5_d_ack",   b1.d_ack,   0);
    chk("drop_c5_if_data", b1.if_data, 32'h2401_0005);
    chk("drop_c5_state",   st1,        0);
    tick();
    chk("drop_c6_acks", {b1.if_ack, b1.d_ack}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
